// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit scheduler.
// This package holds the mux-select encodings, the scheduler states, the default
// timing constants and the arbitration helpers.
package eth_pkg;

    // TX output mux select encodings.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ARP  = 2'd1,
        SEL_ICMP = 2'd2,
        SEL_CMD  = 2'd3
    } tx_sel_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } sched_state_t;

    localparam int DEF_IFG_CYCLES     = 12;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_CNT_W          = 16;

    // Source indices into the request vectors: 0 ARP, 1 ICMP, 2 CMD.
    localparam int NUM_SRC = 3;

    // Fixed-priority pick: ARP > ICMP > CMD.
    function automatic tx_sel_t pick_source(input logic [NUM_SRC-1:0] req);
        tx_sel_t sel;
        sel = SEL_NONE;
        if (req[0])      sel = SEL_ARP;
        else if (req[1]) sel = SEL_ICMP;
        else if (req[2]) sel = SEL_CMD;
        return sel;
    endfunction

    // One-hot start vector (bit order ARP, ICMP, CMD) for a select value.
    function automatic logic [NUM_SRC-1:0] sel_onehot(input tx_sel_t sel);
        logic [NUM_SRC-1:0] oh;
        oh = '0;
        case (sel)
            SEL_ARP:  oh = 3'b001;
            SEL_ICMP: oh = 3'b010;
            SEL_CMD:  oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/eth_tx_sched_req_latch.sv
// Single-slot pending request latch for one transmit source.
// A flush beats a new trigger, and a new trigger beats the grant clear. This means that
// a request arriving in the start cycle is kept as a fresh one. A trigger that
// lands on an already-pending slot is reported as a coalesce strobe.
module tx_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clear,
    input  logic flush,
    output logic pending,
    output logic coalesce
);

    // The merge strobe fires only when the trigger is absorbed by an existing request.
    assign coalesce = set & pending & ~clear & ~flush;

    // Pending flag with flush > set > clear precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (flush) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Ethernet TX scheduler.
// The block latches ARP, ICMP and CMD transmit requests and grants them one at a time,
// using fixed priority, onto the shared frame-builder path. It then waits for frame
// completion under a watchdog and inserts an inter-frame gap before the next grant.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             CLK_125M,
    input  logic             SYS_RST_N,
    input  logic             TRIG_TX_ARP,
    input  logic             TRIG_TX_ICMP,
    input  logic             TRIG_TX_CMD,
    input  logic             TRIG_PACK_RST,
    input  logic             TX_DONE,
    output logic             TX_ARP_START,
    output logic             TX_ICMP_START,
    output logic             TX_CMD_START,
    output logic [1:0]       TX_SEL,
    output logic             TX_ABORT,
    output logic             SCHED_BUSY,
    output logic [CNT_W-1:0] COALESCE_CNT
);

    // One counter serves both the watchdog and the gap, so it is sized for the larger of the two.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]         rst_sync_reg;
    logic               rst_n;
    logic [NUM_SRC-1:0] trig, clr, fl, pend, coal, eligible;
    tx_sel_t            grant;

    sched_state_t       state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    tx_sel_t            sel_reg, sel_next;
    logic [NUM_SRC-1:0] start_reg, start_next;
    logic               abort_reg, abort_next;
    logic               busy_reg, busy_next;
    logic [CNT_W-1:0]   coal_cnt_reg, coal_cnt_next;
    logic [1:0]         coal_sum;
    logic [CNT_W:0]     coal_ext;

    // Reset assertion is asynchronous. Release is resynchronised to the clock.
    always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) rst_sync_reg <= 2'b00;
        else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    assign trig = {TRIG_TX_CMD, TRIG_TX_ICMP, TRIG_TX_ARP};
    assign clr  = start_reg;
    assign fl   = {TRIG_PACK_RST, 2'b00};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_req
            tx_req_latch u_latch (
                .clk      (CLK_125M),
                .rst_n    (rst_n),
                .set      (trig[gi]),
                .clear    (clr[gi]),
                .flush    (fl[gi]),
                .pending  (pend[gi]),
                .coalesce (coal[gi])
            );
        end
    endgenerate

    // A CMD request being flushed in this cycle must not be granted in this cycle.
    assign eligible = pend & ~fl;
    assign grant    = pick_source(eligible);

    // Next-state logic and the values for the registered outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = SEL_NONE;
        start_next = '0;
        abort_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant != SEL_NONE) begin
                    state_next = ST_START;
                    sel_next   = grant;
                    start_next = sel_onehot(grant);
                end
            end
            ST_START: begin
                state_next = ST_WAIT_DONE;
                cnt_next   = '0;
                sel_next   = sel_reg;
            end
            ST_WAIT_DONE: begin
                cnt_next = cnt_reg + CW'(1);
                sel_next = sel_reg;
                if (TX_DONE) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                    sel_next   = SEL_NONE;
                end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1) ||
                             (sel_reg == SEL_CMD && TRIG_PACK_RST)) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                    sel_next   = SEL_NONE;
                    abort_next = 1'b1;
                end
            end
            ST_GAP: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(IFG_CYCLES - 1)) begin
                    cnt_next = '0;
                    // Grant straight out of the last gap cycle so that queued frames go
                    // exactly IFG_CYCLES+1 cycles after the previous TX_DONE.
                    if (grant != SEL_NONE) begin
                        state_next = ST_START;
                        sel_next   = grant;
                        start_next = sel_onehot(grant);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // Saturating count of triggers that were merged into an already-pending request.
    always_comb begin
        coal_sum      = {1'b0, coal[0]} + {1'b0, coal[1]} + {1'b0, coal[2]};
        coal_ext      = {1'b0, coal_cnt_reg} + {{(CNT_W - 1){1'b0}}, coal_sum};
        coal_cnt_next = coal_ext[CNT_W] ? {CNT_W{1'b1}} : coal_ext[CNT_W-1:0];
    end

    // State register, and registers for every output.
    always_ff @(posedge CLK_125M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            sel_reg      <= SEL_NONE;
            start_reg    <= '0;
            abort_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            coal_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            start_reg    <= start_next;
            abort_reg    <= abort_next;
            busy_reg     <= busy_next;
            coal_cnt_reg <= coal_cnt_next;
        end
    end

    assign TX_ARP_START  = start_reg[0];
    assign TX_ICMP_START = start_reg[1];
    assign TX_CMD_START  = start_reg[2];
    assign TX_SEL        = sel_reg;
    assign TX_ABORT      = abort_reg;
    assign SCHED_BUSY    = busy_reg;
    assign COALESCE_CNT  = coal_cnt_reg;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed testbench for eth_tx_sched with IFG_CYCLES=12 and TIMEOUT_CYCLES=32.
// All expected values are worked out by hand from the cycle timing of the scheduler.
module tb_eth_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        trig_arp = 1'b0, trig_icmp = 1'b0, trig_cmd = 1'b0, pack_rst = 1'b0;
    logic        tx_done = 1'b0;
    logic        arp_start, icmp_start, cmd_start, tx_abort, busy;
    logic [1:0]  tx_sel;
    logic [15:0] coal_cnt;
    logic [2:0]  starts;

    int n_checks = 0;
    int n_fail   = 0;

    eth_tx_sched #(
        .IFG_CYCLES     (12),
        .TIMEOUT_CYCLES (32),
        .CNT_W          (16)
    ) dut (
        .CLK_125M      (clk),
        .SYS_RST_N     (rst_n),
        .TRIG_TX_ARP   (trig_arp),
        .TRIG_TX_ICMP  (trig_icmp),
        .TRIG_TX_CMD   (trig_cmd),
        .TRIG_PACK_RST (pack_rst),
        .TX_DONE       (tx_done),
        .TX_ARP_START  (arp_start),
        .TX_ICMP_START (icmp_start),
        .TX_CMD_START  (cmd_start),
        .TX_SEL        (tx_sel),
        .TX_ABORT      (tx_abort),
        .SCHED_BUSY    (busy),
        .COALESCE_CNT  (coal_cnt)
    );

    assign starts = {cmd_start, icmp_start, arp_start};

    always #4 clk = ~clk;

    // Advance one cycle and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        run(3);
        chk("rst_starts", 32'(starts), 0);
        chk("rst_sel",    32'(tx_sel), 0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_abort",  32'(tx_abort), 0);
        chk("rst_coal",   32'(coal_cnt), 0);
        rst_n = 1'b1;
        run(4);
        chk("post_rst_busy", 32'(busy), 0);

        // T1: a single ARP request. START comes 2 cycles after the trigger, and the gap is 12 cycles.
        trig_arp = 1'b1; step(); trig_arp = 1'b0;
        chk("t1_no_early_start", 32'(starts), 0);
        step();
        chk("t1_arp_start", 32'(starts), 3'b001);
        chk("t1_sel_arp",   32'(tx_sel), 1);
        chk("t1_busy",      32'(busy),   1);
        step();
        chk("t1_start_pulse", 32'(starts), 0);
        chk("t1_sel_hold",    32'(tx_sel), 1);
        run(27);
        tx_done = 1'b1;
        chk("t1_sel_last_wait", 32'(tx_sel), 1);
        step(); tx_done = 1'b0;
        chk("t1_sel_cleared", 32'(tx_sel), 0);
        chk("t1_no_abort",    32'(tx_abort), 0);
        chk("t1_busy_gap",    32'(busy), 1);
        run(11);
        chk("t1_busy_last_gap", 32'(busy), 1);
        step();
        chk("t1_idle", 32'(busy), 0);

        // T2: three simultaneous triggers are served ARP, then ICMP, then CMD, each 13 cycles after TX_DONE.
        trig_arp = 1'b1; trig_icmp = 1'b1; trig_cmd = 1'b1;
        step();
        trig_arp = 1'b0; trig_icmp = 1'b0; trig_cmd = 1'b0;
        step();
        chk("t2_arp_start", 32'(starts), 3'b001);
        step();
        pulse_done();
        run(11);
        chk("t2_gap_no_start", 32'(starts), 0);
        chk("t2_gap_sel",      32'(tx_sel), 0);
        step();
        chk("t2_icmp_start", 32'(starts), 3'b010);
        chk("t2_sel_icmp",   32'(tx_sel), 2);
        step();
        pulse_done();
        run(12);
        chk("t2_cmd_start", 32'(starts), 3'b100);
        chk("t2_sel_cmd",   32'(tx_sel), 3);
        step();
        pulse_done();
        run(12);
        chk("t2_idle",     32'(busy),   0);
        chk("t2_no_start", 32'(starts), 0);

        // T3: while CMD is active, three more CMD triggers give one more frame and COALESCE_CNT=2.
        trig_cmd = 1'b1; step(); trig_cmd = 1'b0; step();
        chk("t3_cmd_start", 32'(starts), 3'b100);
        step();
        for (int k = 0; k < 3; k++) begin
            trig_cmd = 1'b1; step(); trig_cmd = 1'b0; step();
        end
        chk("t3_coal_cnt", 32'(coal_cnt), 2);
        chk("t3_sel_cmd",  32'(tx_sel), 3);
        pulse_done();
        run(12);
        chk("t3_cmd_again", 32'(starts), 3'b100);
        step();
        pulse_done();
        run(12);
        chk("t3_idle",     32'(busy),   0);
        chk("t3_no_third", 32'(starts), 0);
        step();
        chk("t3_still_none", 32'(starts), 0);

        // T4: the watchdog aborts on the 32nd WAIT_DONE cycle, and then the pending ICMP is served.
        trig_arp = 1'b1; trig_icmp = 1'b1; step();
        trig_arp = 1'b0; trig_icmp = 1'b0; step();
        chk("t4_arp_start", 32'(starts), 3'b001);
        run(32);
        chk("t4_sel_before_to", 32'(tx_sel),   1);
        chk("t4_no_abort_yet",  32'(tx_abort), 0);
        step();
        chk("t4_abort",     32'(tx_abort), 1);
        chk("t4_sel_clear", 32'(tx_sel),   0);
        chk("t4_busy_gap",  32'(busy),     1);
        step();
        chk("t4_abort_pulse", 32'(tx_abort), 0);
        run(11);
        chk("t4_icmp_start", 32'(starts), 3'b010);
        chk("t4_sel_icmp",   32'(tx_sel), 2);
        step();
        pulse_done();
        run(12);
        chk("t4_idle", 32'(busy), 0);

        // T5: TRIG_PACK_RST during CMD WAIT_DONE aborts, clears the pending CMD, and overrides a coincident trigger.
        trig_cmd = 1'b1; step(); trig_cmd = 1'b0; step();
        chk("t5_cmd_start", 32'(starts), 3'b100);
        step();
        trig_cmd = 1'b1; step(); trig_cmd = 1'b0;
        pack_rst = 1'b1; trig_cmd = 1'b1; step();
        pack_rst = 1'b0; trig_cmd = 1'b0;
        chk("t5_abort",     32'(tx_abort), 1);
        chk("t5_sel_clear", 32'(tx_sel),   0);
        run(12);
        chk("t5_idle",     32'(busy),   0);
        chk("t5_no_start", 32'(starts), 0);
        step();
        chk("t5_still_none", 32'(starts), 0);
        chk("t5_coal_kept",  32'(coal_cnt), 2);

        // T6: an asynchronous reset in WAIT_DONE clears the outputs at once and drops the pending CMD.
        trig_arp = 1'b1; trig_cmd = 1'b1; step();
        trig_arp = 1'b0; trig_cmd = 1'b0; step();
        chk("t6_arp_start", 32'(starts), 3'b001);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_async_sel",  32'(tx_sel),   0);
        chk("t6_async_busy", 32'(busy),     0);
        chk("t6_async_coal", 32'(coal_cnt), 0);
        run(2);
        rst_n = 1'b1;
        run(6);
        chk("t6_stay_idle", 32'(busy),   0);
        chk("t6_no_start",  32'(starts), 0);
        trig_icmp = 1'b1; step(); trig_icmp = 1'b0; step();
        chk("t6_new_icmp", 32'(starts), 3'b010);
        step();
        pulse_done();
        run(12);
        chk("t6_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit scheduler for the Ethernet engine: takes the single-cycle trigger pulses raised by the receive side (ARP request, ICMP echo, UDP command) and serialises them onto the one shared TX frame-builder path.
- Latches each request, arbitrates with fixed priority, and issues a start pulse plus mux select to the chosen builder.
- Waits for frame completion under a watchdog, then enforces an inter-frame gap before the next grant.

Parameters:
IFG_CYCLES, 12, idle cycles inserted after each frame end/abort before next grant (min 1)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_DONE before forced abort (min 2)
CNT_W, 16, width of coalesce counter

Ports:
CLK_125M  in  1  system clock, 125 MHz
SYS_RST_N  in  1  asynchronous active-low reset
TRIG_TX_ARP  in  1  1-cycle pulse: ARP reply required
TRIG_TX_ICMP  in  1  1-cycle pulse: ICMP echo reply required
TRIG_TX_CMD  in  1  1-cycle pulse: UDP command response required
TRIG_PACK_RST  in  1  1-cycle pulse: flush pending/active CMD transmission
TX_DONE  in  1  builder pulse: last beat of current frame accepted
TX_ARP_START  out  1  1-cycle start to ARP builder
TX_ICMP_START  out  1  1-cycle start to ICMP builder
TX_CMD_START  out  1  1-cycle start to CMD builder
TX_SEL  out  2  output mux select: 0 none, 1 ARP, 2 ICMP, 3 CMD
TX_ABORT  out  1  1-cycle pulse: active frame abandoned (timeout or CMD flush)
SCHED_BUSY  out  1  high in any state other than IDLE
COALESCE_CNT  out  CNT_W  saturating count of triggers merged into an already-pending request

Behaviour:
- Reset (async assert, sync release): state IDLE, all pending flags 0, all outputs 0, counters 0.
- Pending latch per source: trigger sets flag next edge. Flag clears on the cycle its START is issued. A trigger in that same cycle leaves the flag set, as a new request. A trigger while the flag is already set increments COALESCE_CNT, which saturates at all-ones.
- TRIG_PACK_RST clears the CMD pending flag. TRIG_PACK_RST wins over a simultaneous TRIG_TX_CMD.
- FSM states: IDLE, START, WAIT_DONE, GAP.
  - IDLE: if any flag is set, grant by priority ARP > ICMP > CMD, register TX_SEL, go START.
  - START: one cycle. The matching TX_*_START is high and the granted flag clears. Go WAIT_DONE with the timeout counter at 0.
  - WAIT_DONE: the counter increments each cycle.
    - TX_DONE → GAP.
    - Counter reaches TIMEOUT_CYCLES-1 without TX_DONE → TX_ABORT pulse, go GAP.
    - TX_SEL==3 and TRIG_PACK_RST → TX_ABORT pulse, go GAP.
    - TX_DONE coincident with a timeout/flush counts as normal completion, with no abort.
  - GAP: TX_SEL=0. Hold IFG_CYCLES cycles, then IDLE.
- TX_DONE outside WAIT_DONE is ignored.
- Latency: trigger high at cycle t with FSM idle → START pulse at cycle t+2. Next grant comes no earlier than IFG_CYCLES+1 cycles after the TX_DONE cycle.
- TX_SEL holds its value from START through the last WAIT_DONE cycle and is 0 otherwise.
- START outputs are one-hot; at most one is high per cycle.
- All outputs are registered.
- Triggers arriving in any state are latched and never lost. Each source has a single pending slot, so repeats coalesce.

Decomposition:
- Shared package eth_pkg holds:
  - TX_SEL encodings (SEL_NONE=0, SEL_ARP=1, SEL_ICMP=2, SEL_CMD=3)
  - FSM state enum
  - default IFG/timeout constants
- One natural sub-module: tx_req_latch, one per source. Inputs: set, clear, flush. Outputs: pending flag and coalesce strobe.

Test Plan:
- Single ARP trigger at cycle 10 → TX_ARP_START at cycle 12, TX_SEL=1 from 12. TX_DONE at 40 → TX_SEL=0 at 41, SCHED_BUSY low at cycle 53 (IFG 12).
- ARP, ICMP and CMD triggers all in the same cycle → grants in order ARP, ICMP, CMD. Each start follows the prior TX_DONE by 13 cycles. No START overlaps.
- CMD active plus three extra TRIG_TX_CMD pulses → exactly one further CMD frame; COALESCE_CNT=2.
- No TX_DONE after START (TIMEOUT_CYCLES=16) → TX_ABORT on the 16th WAIT_DONE cycle, GAP, then the next pending request is served.
- CMD in WAIT_DONE plus TRIG_PACK_RST, with CMD also pending → TX_ABORT next cycle, pending cleared, no further CMD START. A coincident TRIG_TX_CMD is discarded.
- SYS_RST_N pulled low mid WAIT_DONE → all outputs 0 immediately (async), pending flags cleared. After release the block stays idle until a new trigger arrives.
